tile_sprite_writer: RTL and testbench
=====================================

# tile_sprite_writer

Consumer end of the `game_board_reader` handshake. When the reader presents a tile in its write-out phase, this block expands the tile code into an 8x8 block of pixels. It fetches each pixel from the synchronous sprite ROM and writes it into the 224x248 frame buffer. When the tile is finished, it pulses `next_sprite` so the reader advances to the next board position. It sits between the board reader/tile register, the sprite ROM and the frame-buffer write port.

## Interface
Parameters:
- `TILE_DIM`, 8: tile edge in pixels; fixed to a power of two, with `log2` = 3.
- `FB_WIDTH`, 224: frame-buffer row pitch in pixels (28 tiles x 8).

Ports:
- `Clk` in 1: single system clock; all state changes on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `write_out` in 1: reader is in its write-out phase; the tile inputs are valid.
- `complete` in 1: reader has finished the board; qualifies `write_out`.
- `tile_code` in 4: sprite index from the reader's loaded tile register.
- `game_x` in 5: tile column, 0..27.
- `game_y` in 5: tile row, 0..30.
- `next_sprite` out 1: one-cycle request to the reader for the next tile.
- `frame_done` out 1: one-cycle pulse at end of board.
- `rom_addr` out 10: `{tile_code_r, py, px}` to the sprite ROM.
- `rom_data` in 4: pixel colour index; 1-cycle read latency.
- `fb_we` out 1: frame-buffer write strobe.
- `fb_addr` out 16: frame-buffer pixel address.
- `fb_data` out 4: pixel colour; 0 whenever `fb_we` is 0.
- `fb_ready` in 1: frame buffer accepts the write in the current cycle.

## Operation
- Internal registers: `tile_code_r[3:0]`, `tx[4:0]`, `ty[4:0]`, `px[2:0]`, `py[2:0]`.
- States: IDLE, FETCH, WRITE, HANDOFF, WAIT_LOW.
- IDLE:
  - `write_out & complete`: `frame_done` = 1 for this cycle; no draw; stay in IDLE.
  - `write_out & !complete`: capture `tile_code`, `game_x`, `game_y`; clear `px` and `py`; go to FETCH.
- FETCH (1 cycle):
  - `rom_addr` = `{tile_code_r, py, px}`.
  - Register `fb_addr` = `(ty*8+py)*FB_WIDTH + (tx*8+px)`.
  - Row is 8 bits (max 247), column is 8 bits (max 223), product is 16 bits (max 55551); no truncation anywhere.
  - Go to WRITE.
- WRITE:
  - `rom_addr` is held, so `rom_data` stays valid.
  - `fb_we` = 1, `fb_data` = `rom_data`.
  - Hold in WRITE, with all outputs unchanged, while `fb_ready` = 0.
  - On `fb_ready` = 1 with `px` = 7 and `py` = 7: go to HANDOFF.
  - On `fb_ready` = 1 otherwise: increment `px`; on `px` wrap 7→0, increment `py`; go to FETCH.
- HANDOFF (1 cycle): `next_sprite` = 1; go to WAIT_LOW.
- WAIT_LOW: stay until `write_out` = 0, then go to IDLE. This guarantees one draw per reader tile even if `write_out` lingers.
- Colour 0 is written like any other colour; no transparency.
- Tile inputs are sampled only in IDLE. Changes during a draw are ignored.

## Timing
- Reset values (asserted asynchronously):
  - State = IDLE.
  - `next_sprite`, `frame_done`, `fb_we` = 0.
  - `fb_addr`, `fb_data`, `rom_addr` = 0.
  - All internal registers = 0.
- Reset mid-draw abandons the tile; already-written pixels remain; no `next_sprite` is issued.
- Latency with `fb_ready` tied to 1:
  - Cycle 0 is the IDLE cycle that captures the tile.
  - Pixels are written in cycles 2, 4, …, 128.
  - `next_sprite` is high in cycle 129.
- Each cycle of `fb_ready` = 0 adds exactly one cycle.
- The reader leaves write-out on the same edge that samples `next_sprite`. WAIT_LOW therefore normally lasts 1 cycle.
- Minimum tile period is 131 cycles.
- `next_sprite` and `frame_done` are never high together. Each is never high for more than 1 cycle.

## Test plan
- **Reset:** assert `Reset` = 0 asynchronously between edges → all outputs 0 immediately; after release, state is IDLE with `fb_we` = 0.
- **Tile (0,0), `tile_code` = 3, `fb_ready` = 1:**
  - 64 writes at addresses 0–7, 224–231, …, 1568–1575.
  - `rom_addr` runs 192–255.
  - `fb_data` matches the ROM model.
  - `next_sprite` is high only in cycle 129.
- **Corner tile (27,30):** first `fb_addr` = 53976, last = 55551; row stride is 224.
- **Backpressure:** hold `fb_ready` = 0 for 5 cycles on pixel 10 → `fb_we`, `fb_addr` and `fb_data` are stable throughout; no skipped or duplicated pixel; `next_sprite` is high in cycle 134.
- **Board end:** `write_out` = 1 with `complete` = 1 → `frame_done` pulses for 1 cycle; no `fb_we`; no `next_sprite`.
- **Mid-tile reset:** assert reset at pixel 20, release, then present a new tile → drawing restarts at pixel 0 of the new tile.

Source files
------------

// File: rtl/tile_sprite_writer.sv
// tile_sprite_writer
//
// Expands one board tile into an 8x8 block of frame-buffer pixels. The tile
// code and board position are captured from the board reader. Each pixel
// colour is fetched from the synchronous sprite ROM and written to the frame
// buffer. When the tile is finished, next_sprite asks the reader for the next
// tile.
//
// Ports
//   Clk          system clock, rising edge
//   Reset        asynchronous, active-low reset
//   write_out    reader is in its write-out phase; tile inputs are valid
//   complete     reader has finished the board (qualifies write_out)
//   tile_code    sprite index of the presented tile
//   game_x       tile column, 0..27
//   game_y       tile row, 0..30
//   next_sprite  one-cycle request for the next tile
//   frame_done   one-cycle pulse at end of board
//   rom_addr     {tile_code, py, px} to the sprite ROM
//   rom_data     pixel colour from the ROM, one cycle after rom_addr
//   fb_we        frame-buffer write strobe
//   fb_addr      frame-buffer pixel address
//   fb_data      pixel colour, 0 when fb_we is low
//   fb_ready     frame buffer accepts the write this cycle
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a tile; frame_done when the board is complete
// FETCH    | ROM address for the current pixel presented, fb_addr computed
// WRITE    | ROM data valid, write held until fb_ready
// HANDOFF  | next_sprite pulse to the reader
// WAIT_LOW | waiting for write_out to drop, so each tile is drawn only once

module tile_sprite_writer #(
    parameter int TILE_DIM = 8,
    parameter int FB_WIDTH = 224
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        write_out,
    input  logic        complete,
    input  logic [3:0]  tile_code,
    input  logic [4:0]  game_x,
    input  logic [4:0]  game_y,
    output logic        next_sprite,
    output logic        frame_done,
    output logic [9:0]  rom_addr,
    input  logic [3:0]  rom_data,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [3:0]  fb_data,
    input  logic        fb_ready
);

    localparam int TILE_LOG2 = $clog2(TILE_DIM);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        HANDOFF,
        WAIT_LOW
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             tile_code_q, tile_code_d;
    logic [4:0]             tx_q, tx_d;
    logic [4:0]             ty_q, ty_d;
    logic [TILE_LOG2-1:0]   px_q, px_d;
    logic [TILE_LOG2-1:0]   py_q, py_d;
    logic [15:0]            fb_addr_q, fb_addr_d;

    // Because the tile edge is a power of two, ty*8+py is a concatenation.
    // This gives an 8-bit row (max 247) and an 8-bit column (max 223).
    logic [7:0] pix_row;
    logic [7:0] pix_col;

    assign pix_row = {ty_q, py_q};
    assign pix_col = {tx_q, px_q};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            tile_code_q <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            fb_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            tile_code_q <= tile_code_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            px_q        <= px_d;
            py_q        <= py_d;
            fb_addr_q   <= fb_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tile_code_d = tile_code_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        px_d        = px_q;
        py_d        = py_q;
        fb_addr_d   = fb_addr_q;

        unique case (state_q)
            IDLE: begin
                if (write_out && !complete) begin
                    tile_code_d = tile_code;
                    tx_d        = game_x;
                    ty_d        = game_y;
                    px_d        = '0;
                    py_d        = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                fb_addr_d = 16'(pix_row) * 16'(FB_WIDTH) + 16'(pix_col);
                state_d   = WRITE;
            end
            WRITE: begin
                // px/py only move when the write is accepted. This keeps
                // rom_addr, and therefore rom_data, stable during a stall.
                if (fb_ready) begin
                    if (px_q == '1 && py_q == '1) begin
                        state_d = HANDOFF;
                    end else begin
                        px_d = px_q + 1'b1;
                        if (px_q == '1) begin
                            py_d = py_q + 1'b1;
                        end
                        state_d = FETCH;
                    end
                end
            end
            HANDOFF: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!write_out) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_addr    = {tile_code_q, py_q, px_q};
    assign fb_addr     = fb_addr_q;
    assign fb_we       = (state_q == WRITE);
    assign fb_data     = (state_q == WRITE) ? rom_data : 4'd0;
    assign next_sprite = (state_q == HANDOFF);
    assign frame_done  = (state_q == IDLE) && write_out && complete;

endmodule

// File: tb/tb_tile_sprite_writer.sv
module tb_tile_sprite_writer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        write_out = 1'b0;
    logic        complete = 1'b0;
    logic [3:0]  tile_code = 4'd0;
    logic [4:0]  game_x = 5'd0;
    logic [4:0]  game_y = 5'd0;
    logic        next_sprite;
    logic        frame_done;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_ready = 1'b1;

    int total = 0;
    int bad = 0;

    tile_sprite_writer #(.TILE_DIM(8), .FB_WIDTH(224)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .write_out   (write_out),
        .complete    (complete),
        .tile_code   (tile_code),
        .game_x      (game_x),
        .game_y      (game_y),
        .next_sprite (next_sprite),
        .frame_done  (frame_done),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_ready    (fb_ready)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_fn(input logic [9:0] a);
        return a[3:0] ^ a[9:6] ^ {a[5:4], a[5:4]};
    endfunction

    // sprite ROM model with one cycle of read latency
    always @(posedge Clk) rom_data <= rom_fn(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Called in an IDLE cycle; that cycle is cycle 0 of the tile.
    task automatic draw(input logic [3:0] tc, input logic [4:0] gx, input logic [4:0] gy,
                        input int stall_pix, input int stall_n, input int abort_pix);
        int pix;
        int stalls;
        int ns_cyc;
        int cyc;
        int px;
        int py;
        logic [2:0] px3;
        logic [2:0] py3;
        pix = 0;
        stalls = 0;
        ns_cyc = -1;
        cyc = 0;
        write_out = 1'b1;
        complete = 1'b0;
        tile_code = tc;
        game_x = gx;
        game_y = gy;
        fb_ready = 1'b1;
        #1;
        chk("idle_frame_done", frame_done, 0);
        chk("idle_fb_we", fb_we, 0);
        for (int i = 0; i < 400; i++) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                // tile inputs wander during the draw and must be ignored
                tile_code = ~tc;
                game_x = gx ^ 5'd5;
                game_y = gy ^ 5'd9;
            end
            if (fb_we) begin
                px = pix % 8;
                py = pix / 8;
                px3 = px[2:0];
                py3 = py[2:0];
                chk("fb_addr", fb_addr, (gy * 8 + py) * 224 + gx * 8 + px);
                chk("rom_addr", rom_addr, {22'd0, tc, py3, px3});
                chk("fb_data", fb_data, rom_fn({tc, py3, px3}));
                chk("write_cycle", cyc, 2 * pix + 2 + stalls);
                if (pix == abort_pix) return;
                if (pix == stall_pix && stalls < stall_n) begin
                    fb_ready = 1'b0;
                    stalls++;
                end else begin
                    fb_ready = 1'b1;
                    pix++;
                end
            end else begin
                fb_ready = 1'b1;
                chk("fb_data_when_idle", fb_data, 0);
            end
            chk("frame_done_in_draw", frame_done, 0);
            if (next_sprite) begin
                ns_cyc = cyc;
                write_out = 1'b0;
                break;
            end
        end
        chk("next_sprite_cycle", ns_cyc, 129 + stall_n);
        chk("pixel_count", pix, 64);
        tick();
        chk("wait_low_next_sprite", next_sprite, 0);
        chk("wait_low_fb_we", fb_we, 0);
        tick();
        chk("back_idle_fb_we", fb_we, 0);
    endtask

    initial begin
        // asynchronous reset between edges
        #2 Reset = 1'b0;
        #1;
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_next_sprite", next_sprite, 0);
        chk("rst_frame_done", frame_done, 0);
        #10 Reset = 1'b1;
        tick();
        chk("post_rst_fb_we", fb_we, 0);
        chk("post_rst_next_sprite", next_sprite, 0);

        draw(4'd3, 5'd0, 5'd0, -1, 0, -1);
        draw(4'd9, 5'd27, 5'd30, -1, 0, -1);
        draw(4'd5, 5'd4, 5'd2, 10, 5, -1);
        draw(4'd0, 5'd13, 5'd7, 0, 1, -1);

        // board end
        write_out = 1'b1;
        complete = 1'b1;
        #1;
        chk("board_end_frame_done", frame_done, 1);
        chk("board_end_fb_we", fb_we, 0);
        chk("board_end_next_sprite", next_sprite, 0);
        tick();
        write_out = 1'b0;
        complete = 1'b0;
        #1;
        chk("board_end_pulse_len", frame_done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("board_end_no_write", fb_we, 0);
            chk("board_end_no_ns", next_sprite, 0);
        end

        // mid-tile reset at pixel 20, then a fresh tile
        draw(4'd12, 5'd10, 5'd15, -1, 0, 20);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_fb_we", fb_we, 0);
        chk("mid_rst_fb_addr", fb_addr, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_next_sprite", next_sprite, 0);
        write_out = 1'b0;
        fb_ready = 1'b1;
        tick();
        chk("in_rst_fb_we", fb_we, 0);
        #2 Reset = 1'b1;
        draw(4'd7, 5'd1, 5'd1, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
